cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Write-side producer for the dual-port frame buffer. Runs on the camera pixel clock.
- Takes the OV7670-style byte stream (VSYNC/HREF framing, RGB565 sent as two bytes per pixel) and reduces each pixel to RGB111.
- Drives the buffer write port: address, 3-bit pixel data and the write strobe. The buffer samples these on the falling edge of its write clock, which is this block's clock.

Parameters:
- AW, 15, write-address width; must match the frame buffer.
- DW, 3, pixel data width; fixed RGB111, bit 2 = R, bit 1 = G, bit 0 = B.
- IMG_W, 160, pixels per line.
- IMG_H, 120, lines per frame; IMG_W*IMG_H must be ≤ 2**AW.

Ports:
- clk  input  1  camera pixel clock (PCLK); all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- vsync  input  1  camera frame sync; high = vertical blanking.
- href  input  1  camera line valid; high = pixel bytes on px_data.
- px_data  input  8  camera data byte.
- addr_in  output  AW  buffer write address.
- data_in  output  DW  RGB111 pixel to the buffer.
- regwrite  output  1  buffer write enable; one cycle per pixel.
- frame_done  output  1  one-cycle pulse at end of a captured frame.
- overrun  output  1  sticky flag: camera delivered more than IMG_W*IMG_H pixels this frame.

Behaviour:
- Reset (asynchronous):
  - addr_in=0, data_in=0, regwrite=0, frame_done=0, overrun=0.
  - Internal: state=WAIT_FRAME, pix_cnt=0, byte phase=FIRST, vsync_d=0, held first byte=0.
- Edge detect: vsync_d registers vsync every cycle.
  - Frame start = vsync_d=1 and vsync=0.
  - Frame end = vsync_d=0 and vsync=1.
  - Because vsync_d resets to 0, a frame that is already in progress when reset is released is ignored; capture begins only after a full high-to-low vsync transition.
- State WAIT_FRAME:
  - regwrite=0; href is ignored.
  - On frame start: clear pix_cnt and overrun, set phase=FIRST, go to CAPTURE.
- State CAPTURE, per cycle:
  - href=0: phase forced to FIRST. A pending lone first byte is discarded and nothing is written.
  - href=1, phase FIRST: store px_data as byte1; phase←SECOND.
  - href=1, phase SECOND, pix_cnt < IMG_W*IMG_H:
    - data_in←{byte1[7], byte1[2], px_data[4]} (MSBs of R5, G6, B5).
    - addr_in←pix_cnt; regwrite←1; pix_cnt←pix_cnt+1; phase←FIRST.
  - href=1, phase SECOND, pix_cnt = IMG_W*IMG_H: no write, overrun←1, phase←FIRST.
  - In every cycle without a completed pixel, regwrite←0. regwrite is never high for two consecutive cycles.
  - On frame end: frame_done←1 for exactly one cycle, regwrite←0, go to WAIT_FRAME. A half-received pixel is dropped.
- Latency:
  - The second-byte edge registers the pixel, so regwrite/addr_in/data_in are valid for the following cycle and stable across its falling edge.
  - addr_in and data_in hold their last values while regwrite=0.
- Timing and ordering:
  - One pixel completes every 2 href-high cycles.
  - Addresses are strictly sequential from 0; the address does not wrap.
- Simultaneous events:
  - Frame end coincident with a second byte: frame end wins; no write occurs.
  - Frame start is only checked in WAIT_FRAME.
  - Reset asserted mid-frame: all outputs clear immediately, regwrite is dropped asynchronously, and capture resumes only at the next frame start.
- Short frame (fewer than IMG_W*IMG_H pixels): the remaining buffer locations keep their old contents; frame_done still pulses.

Test Plan:
- Reset release with vsync low, then href bursts → regwrite stays 0, frame_done stays 0.
- vsync 1→0, then one href line of 2*IMG_W bytes alternating 0xF8,0x1F → IMG_W writes to addr 0..159, data_in=3'b101, regwrite high once per 2 clocks.
- Byte pair 0x04,0x10 → data_in=3'b011; pair 0x80,0x00 → 3'b100.
- href drops after an odd byte count (3 bytes) → 1 write only; the next line's first pixel goes to the following address with correct byte pairing.
- Full frame of 120×160 pixels plus 5 extra pixels → last write at addr 19199, overrun=1, no write for the extras; a new vsync falling edge clears overrun and restarts at addr 0.
- Reset asserted mid-line at pixel 50 → regwrite=0 and addr_in=0 immediately; after release, no writes until vsync rises then falls; vsync rising at end of a frame → exactly one frame_done pulse.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture: write-side producer for the dual-port frame buffer.
// Reassembles the OV7670 byte stream (VSYNC/HREF framing, RGB565 as two
// bytes per pixel) into RGB111 pixels and drives the buffer write port.
// All outputs are registered on the rising edge of the pixel clock, so they
// are stable across the falling edge where the buffer samples them.
//
// Write handshake: regwrite is a single-cycle strobe. While it is high,
// addr_in and data_in carry one complete pixel. There is no back-pressure,
// because the buffer accepts every strobe. While regwrite is low, addr_in and
// data_in keep their last values.
module cam_capture #(
  parameter int AW    = 15,
  parameter int DW    = 3,
  parameter int IMG_W = 160,
  parameter int IMG_H = 120
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          vsync,
  input  logic          href,
  input  logic [7:0]    px_data,
  output logic [AW-1:0] addr_in,
  output logic [DW-1:0] data_in,
  output logic          regwrite,
  output logic          frame_done,
  output logic          overrun,
  output logic          state_dbg
);

  // The counter is one bit wider than the address so it can hold the
  // "frame full" value even when IMG_W*IMG_H == 2**AW.
  localparam logic [AW:0] NPIX = (AW+1)'(IMG_W * IMG_H);

  typedef enum logic {
    WAIT_FRAME = 1'b0,
    CAPTURE    = 1'b1
  } state_t;

  localparam logic PH_FIRST  = 1'b0;
  localparam logic PH_SECOND = 1'b1;

  state_t        state_q, state_d;
  logic [AW:0]   pix_cnt_q, pix_cnt_d;
  logic          phase_q, phase_d;
  logic [7:0]    byte1_q, byte1_d;
  logic          vsync_q;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] data_q, data_d;
  logic          regwrite_q, regwrite_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d;

  logic frame_start;
  logic frame_end;

  // A falling vsync opens a frame. A rising vsync closes it. Because vsync_q
  // resets low, a frame already running at reset release is never captured.
  assign frame_start = vsync_q & ~vsync;
  assign frame_end   = ~vsync_q & vsync;

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= WAIT_FRAME;
      pix_cnt_q    <= '0;
      phase_q      <= PH_FIRST;
      byte1_q      <= '0;
      vsync_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      regwrite_q   <= 1'b0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      pix_cnt_q    <= pix_cnt_d;
      phase_q      <= phase_d;
      byte1_q      <= byte1_d;
      vsync_q      <= vsync;
      addr_q       <= addr_d;
      data_q       <= data_d;
      regwrite_q   <= regwrite_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
    end
  end

  // Next-state logic: byte pairing, pixel reduction and frame bookkeeping.
  always_comb begin
    state_d      = state_q;
    pix_cnt_d    = pix_cnt_q;
    phase_d      = phase_q;
    byte1_d      = byte1_q;
    addr_d       = addr_q;
    data_d       = data_q;
    regwrite_d   = 1'b0;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      WAIT_FRAME: begin
        if (frame_start) begin
          pix_cnt_d = '0;
          overrun_d = 1'b0;
          phase_d   = PH_FIRST;
          state_d   = CAPTURE;
        end
      end

      CAPTURE: begin
        if (frame_end) begin
          // Frame end takes priority over a second byte arriving on the same
          // edge. Any half-received pixel is dropped.
          frame_done_d = 1'b1;
          phase_d      = PH_FIRST;
          state_d      = WAIT_FRAME;
        end else if (!href) begin
          // A lone first byte at the end of a line is discarded.
          phase_d = PH_FIRST;
        end else if (phase_q == PH_FIRST) begin
          byte1_d = px_data;
          phase_d = PH_SECOND;
        end else begin
          phase_d = PH_FIRST;
          if (pix_cnt_q < NPIX) begin
            // Keep the MSB of each channel: R5 (byte1[7]), G6 (byte1[2]),
            // and B5 (byte2[4]).
            data_d     = {byte1_q[7], byte1_q[2], px_data[4]};
            addr_d     = pix_cnt_q[AW-1:0];
            regwrite_d = 1'b1;
            pix_cnt_d  = pix_cnt_q + 1'b1;
          end else begin
            overrun_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = WAIT_FRAME;
      end
    endcase
  end

  assign addr_in    = addr_q;
  assign data_in    = data_q;
  assign regwrite   = regwrite_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign state_dbg  = (state_q == CAPTURE);

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: directed testbench for cam_capture.
module tb_cam_capture;

  localparam int AW    = 15;
  localparam int DW    = 3;
  localparam int IMG_W = 160;
  localparam int IMG_H = 120;

  logic          clk;
  logic          reset;
  logic          vsync;
  logic          href;
  logic [7:0]    px_data;
  logic [AW-1:0] addr_in;
  logic [DW-1:0] data_in;
  logic          regwrite;
  logic          frame_done;
  logic          overrun;
  logic          state_dbg;

  int n_checks;
  int n_errors;

  // Write monitor state.
  int            wr_cnt;
  int            fd_cnt;
  int            dbl_cnt;
  int            seq_err;
  logic [AW-1:0] last_addr;
  logic          prev_rw;
  logic          have_addr;

  int wr_base;
  int fd_base;

  cam_capture #(
    .AW(AW), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .vsync      (vsync),
    .href       (href),
    .px_data    (px_data),
    .addr_in    (addr_in),
    .data_in    (data_in),
    .regwrite   (regwrite),
    .frame_done (frame_done),
    .overrun    (overrun),
    .state_dbg  (state_dbg)
  );

  // Clock generation.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sample on the falling edge, where the buffer also samples.
  initial begin
    wr_cnt    = 0;
    fd_cnt    = 0;
    dbl_cnt   = 0;
    seq_err   = 0;
    last_addr = '0;
    prev_rw   = 1'b0;
    have_addr = 1'b0;
    forever begin
      @(negedge clk);
      if (regwrite) begin
        wr_cnt++;
        if (prev_rw) dbl_cnt++;
        if (have_addr && addr_in != '0 && addr_in != last_addr + 1'b1) seq_err++;
        last_addr = addr_in;
        have_addr = 1'b1;
      end
      if (frame_done) fd_cnt++;
      prev_rw = regwrite;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one input byte, then advance past the next rising edge.
  task automatic cyc(input logic v, input logic h, input logic [7:0] d);
    vsync   = v;
    href    = h;
    px_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic v, input int n);
    for (int i = 0; i < n; i++) cyc(v, 1'b0, 8'h00);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset    = 1'b1;
    vsync    = 1'b0;
    href     = 1'b0;
    px_data  = 8'h00;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_rw",    32'(regwrite),   32'd0);
    check("rst_addr",  32'(addr_in),    32'd0);
    check("rst_data",  32'(data_in),    32'd0);
    check("rst_fd",    32'(frame_done), 32'd0);
    check("rst_ovr",   32'(overrun),    32'd0);
    check("rst_state", 32'(state_dbg),  32'd0);
    reset = 1'b0;

    // Release reset mid-frame with vsync low. Href bursts must be ignored.
    wr_base = wr_cnt;
    fd_base = fd_cnt;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'(i * 13));
    idle(1'b0, 2);
    check("pre_wr", 32'(wr_cnt - wr_base), 32'd0);
    check("pre_fd", 32'(fd_cnt - fd_base), 32'd0);

    // Frame start, followed by one full line of 0xF8,0x1F.
    idle(1'b1, 3);
    cyc(1'b0, 1'b0, 8'h00);
    check("start_state", 32'(state_dbg), 32'd1);
    for (int i = 0; i < IMG_W; i++) begin
      cyc(1'b0, 1'b1, 8'hF8);
      check("l1_gap", 32'(regwrite), 32'd0);
      cyc(1'b0, 1'b1, 8'h1F);
      check("l1_we",   32'(regwrite), 32'd1);
      check("l1_addr", 32'(addr_in),  32'(i));
      check("l1_data", 32'(data_in),  32'h5);
    end
    cyc(1'b0, 1'b0, 8'h00);
    check("l1_end_rw", 32'(regwrite), 32'd0);
    check("l1_hold_addr", 32'(addr_in), 32'd159);

    // Additional colour patterns.
    cyc(1'b0, 1'b1, 8'h04);
    cyc(1'b0, 1'b1, 8'h10);
    check("p011_addr", 32'(addr_in), 32'd160);
    check("p011_data", 32'(data_in), 32'h3);
    cyc(1'b0, 1'b1, 8'h80);
    cyc(1'b0, 1'b1, 8'h00);
    check("p100_addr", 32'(addr_in), 32'd161);
    check("p100_data", 32'(data_in), 32'h4);
    cyc(1'b0, 1'b0, 8'h00);

    // Odd byte count: three bytes give one write, and the lone byte is dropped.
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b0, 1'b1, 8'h1F);
    check("odd_addr", 32'(addr_in), 32'd162);
    check("odd_data", 32'(data_in), 32'h5);
    cyc(1'b0, 1'b1, 8'h80);
    check("odd_lone_rw", 32'(regwrite), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    check("odd_gap_rw", 32'(regwrite), 32'd0);
    cyc(1'b0, 1'b1, 8'h04);
    check("odd_nx1_rw", 32'(regwrite), 32'd0);
    cyc(1'b0, 1'b1, 8'h10);
    check("odd_nx_we",   32'(regwrite), 32'd1);
    check("odd_nx_addr", 32'(addr_in),  32'd163);
    check("odd_nx_data", 32'(data_in),  32'h3);
    cyc(1'b0, 1'b0, 8'h00);

    // Frame end produces a single frame_done pulse.
    fd_base = fd_cnt;
    cyc(1'b1, 1'b0, 8'h00);
    check("fe_fd", 32'(frame_done), 32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    check("fe_fd_low", 32'(frame_done), 32'd0);
    check("fe_state",  32'(state_dbg),  32'd0);
    idle(1'b1, 2);
    check("fe_fd_cnt", 32'(fd_cnt - fd_base), 32'd1);

    // Frame end on the same edge as a second byte: no write occurs.
    cyc(1'b0, 1'b0, 8'h00);
    wr_base = wr_cnt;
    cyc(1'b0, 1'b1, 8'hF8);
    cyc(1'b1, 1'b1, 8'h1F);
    check("sim_rw", 32'(regwrite),   32'd0);
    check("sim_fd", 32'(frame_done), 32'd1);
    idle(1'b1, 2);
    check("sim_wr", 32'(wr_cnt - wr_base), 32'd0);

    // Full frame, then 5 extra pixels.
    cyc(1'b0, 1'b0, 8'h00);
    wr_base = wr_cnt;
    for (int l = 0; l < IMG_H; l++) begin
      for (int p = 0; p < IMG_W; p++) begin
        cyc(1'b0, 1'b1, 8'hF8);
        cyc(1'b0, 1'b1, 8'h1F);
      end
      cyc(1'b0, 1'b0, 8'h00);
    end
    check("full_wr",   32'(wr_cnt - wr_base), 32'(IMG_W * IMG_H));
    check("full_last", 32'(last_addr),        32'd19199);
    check("full_ovr",  32'(overrun),          32'd0);
    wr_base = wr_cnt;
    for (int p = 0; p < 5; p++) begin
      cyc(1'b0, 1'b1, 8'h80);
      cyc(1'b0, 1'b1, 8'h00);
      check("extra_rw", 32'(regwrite), 32'd0);
    end
    cyc(1'b0, 1'b0, 8'h00);
    check("extra_wr",   32'(wr_cnt - wr_base), 32'd0);
    check("extra_ovr",  32'(overrun),          32'd1);
    check("extra_addr", 32'(addr_in),          32'd19199);
    cyc(1'b1, 1'b0, 8'h00);
    check("ovr_fd",     32'(frame_done), 32'd1);
    check("ovr_sticky", 32'(overrun),    32'd1);
    cyc(1'b1, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 8'h00);
    check("ovr_clear", 32'(overrun), 32'd0);
    cyc(1'b0, 1'b1, 8'h80);
    cyc(1'b0, 1'b1, 8'h00);
    check("restart_we",   32'(regwrite), 32'd1);
    check("restart_addr", 32'(addr_in),  32'd0);
    check("restart_data", 32'(data_in),  32'h4);

    // Run to pixel 50, then assert reset while the strobe is high.
    for (int p = 1; p < 50; p++) begin
      cyc(1'b0, 1'b1, 8'hF8);
      cyc(1'b0, 1'b1, 8'h1F);
    end
    check("p50_we",   32'(regwrite), 32'd1);
    check("p50_addr", 32'(addr_in),  32'd49);
    reset = 1'b1;
    #1;
    check("arst_rw",   32'(regwrite), 32'd0);
    check("arst_addr", 32'(addr_in),  32'd0);
    check("arst_data", 32'(data_in),  32'd0);
    idle(1'b0, 2);
    reset = 1'b0;
    wr_base = wr_cnt;
    fd_base = fd_cnt;
    for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 8'hF8);
    idle(1'b0, 2);
    check("post_rst_wr", 32'(wr_cnt - wr_base), 32'd0);
    idle(1'b1, 3);
    check("post_rst_fd", 32'(fd_cnt - fd_base), 32'd0);
    cyc(1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b1, 8'h04);
    cyc(1'b0, 1'b1, 8'h10);
    check("resume_we",   32'(regwrite), 32'd1);
    check("resume_addr", 32'(addr_in),  32'd0);
    check("resume_data", 32'(data_in),  32'h3);
    cyc(1'b0, 1'b0, 8'h00);
    idle(1'b1, 5);
    check("resume_fd_cnt", 32'(fd_cnt - fd_base), 32'd1);
    check("no_double_we",  32'(dbl_cnt), 32'd0);
    check("addr_seq",      32'(seq_err), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
